// File: rtl/mips_to_riscv_seq_translator.sv
// Streaming MIPS32 -> RV32IM translator: each accepted MIPS instruction expands into
// 1-4 RISC-V ops that are replayed from a small buffer, one op per output handshake.
module mips_to_riscv_seq_translator #(
   parameter logic [4:0] TMP_REG   = 5'd1,
   parameter logic [4:0] HI_REG    = 5'd26,
   parameter logic [4:0] LO_REG    = 5'd27,
   parameter logic [4:0] LINK_REG  = 5'd31,
   parameter bit         EN_MULDIV = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [1:0]  out_idx,
   output logic        out_last,
   output logic        out_illegal
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MD     = 7'b0000001;

   typedef enum logic {ST_IDLE, ST_EMIT} state_t;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OPC_OP};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
   endfunction

   // off carries byte-offset bits [12:1]
   function automatic logic [31:0] enc_b(input logic [11:0] off, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {off[11], off[9:4], rs2, rs1, f3, off[3:0], off[10], OPC_BR};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, OPC_LUI};
   endfunction

   // off carries byte-offset bits [20:1]
   function automatic logic [31:0] enc_j(input logic [19:0] off, input logic [4:0] rd);
      return {off[19], off[9:0], off[10], off[18:11], rd, OPC_JAL};
   endfunction

   function automatic logic [2:0] imm_f3(input logic [5:0] opc);
      case (opc)
         6'h0A:   return 3'b010;
         6'h0B:   return 3'b011;
         6'h0C:   return 3'b111;
         6'h0D:   return 3'b110;
         6'h0E:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] ls_f3(input logic [5:0] opc);
      case (opc)
         6'h21, 6'h29: return 3'b001;
         6'h23, 6'h2B: return 3'b010;
         6'h24:        return 3'b100;
         6'h25:        return 3'b101;
         default:      return 3'b000;
      endcase
   endfunction

   logic [5:0]  opc_s, funct_s;
   logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
   logic [15:0] imm_s;
   logic        imm_zx_s, imm_fit_s, br_fit_s, j_fit_s, accept_s, xfer_s;
   logic [31:0] imm_v_s, br_w_s, j_tgt_s, j_off_s;
   logic [19:0] imm_hi_s;
   logic [11:0] imm_lo_s, br_off_s;
   logic [3:0]  j_pc_top_s;
   logic [31:0] ops_s [4];
   logic [2:0]  n_s;
   logic        ill_s;

   state_t      state_r;
   logic [2:0]  rem_r;
   logic [31:0] buf_r [4];

   assign opc_s    = in_instr[31:26];
   assign rs_s     = in_instr[25:21];
   assign rt_s     = in_instr[20:16];
   assign rd_s     = in_instr[15:11];
   assign shamt_s  = in_instr[10:6];
   assign funct_s  = in_instr[5:0];
   assign imm_s    = in_instr[15:0];

   assign imm_zx_s  = (opc_s == 6'h0C) || (opc_s == 6'h0D) || (opc_s == 6'h0E);
   assign imm_v_s   = imm_zx_s ? {16'd0, imm_s} : {{16{imm_s[15]}}, imm_s};
   assign imm_fit_s = (imm_v_s[31:11] == {21{imm_v_s[11]}});
   // (v + 0x800) >>> 12 reduces to the upper field plus the rounding bit
   assign imm_hi_s  = imm_v_s[31:12] + {19'd0, imm_v_s[11]};
   assign imm_lo_s  = imm_v_s[11:0];

   // branch offset in words is sx(imm)+1; bytes = words*4
   assign br_w_s   = {{16{imm_s[15]}}, imm_s} + 32'd1;
   assign br_fit_s = (br_w_s[31:10] == {22{br_w_s[10]}});
   assign br_off_s = {br_w_s[10:0], 1'b0};

   assign j_pc_top_s = in_pc[31:28] + {3'd0, &in_pc[27:2]};
   assign j_tgt_s    = {j_pc_top_s, in_instr[25:0], 2'b00};
   assign j_off_s    = j_tgt_s - in_pc;
   // an odd offset (misaligned source PC) cannot be encoded either
   assign j_fit_s    = (j_off_s[31:20] == {12{j_off_s[20]}}) && !j_off_s[0];

   assign in_ready = (rem_r == 3'd0) || ((rem_r == 3'd1) && out_ready);
   assign accept_s = in_valid && in_ready;
   assign xfer_s   = out_valid && out_ready;

   // Decode the incoming MIPS word into its RISC-V expansion.
   always_comb begin
      ops_s[0] = 32'd0;
      ops_s[1] = 32'd0;
      ops_s[2] = 32'd0;
      ops_s[3] = 32'd0;
      n_s      = 3'd1;
      ill_s    = 1'b0;
      case (opc_s)
         6'h00: begin
            case (funct_s)
               6'h20, 6'h21: ops_s[0] = enc_r(7'd0, rt_s, rs_s, 3'b000, rd_s);
               6'h22, 6'h23: ops_s[0] = enc_r(F7_ALT, rt_s, rs_s, 3'b000, rd_s);
               6'h24:        ops_s[0] = enc_r(7'd0, rt_s, rs_s, 3'b111, rd_s);
               6'h25:        ops_s[0] = enc_r(7'd0, rt_s, rs_s, 3'b110, rd_s);
               6'h26:        ops_s[0] = enc_r(7'd0, rt_s, rs_s, 3'b100, rd_s);
               6'h2A:        ops_s[0] = enc_r(7'd0, rt_s, rs_s, 3'b010, rd_s);
               6'h2B:        ops_s[0] = enc_r(7'd0, rt_s, rs_s, 3'b011, rd_s);
               6'h27: begin
                  n_s      = 3'd2;
                  ops_s[0] = enc_r(7'd0, rt_s, rs_s, 3'b110, rd_s);
                  ops_s[1] = enc_i(12'hFFF, rd_s, 3'b100, rd_s, OPC_IMM);
               end
               6'h00: ops_s[0] = enc_i({7'd0, shamt_s}, rt_s, 3'b001, rd_s, OPC_IMM);
               6'h02: ops_s[0] = enc_i({7'd0, shamt_s}, rt_s, 3'b101, rd_s, OPC_IMM);
               6'h03: ops_s[0] = enc_i({F7_ALT, shamt_s}, rt_s, 3'b101, rd_s, OPC_IMM);
               6'h04: ops_s[0] = enc_r(7'd0, rs_s, rt_s, 3'b001, rd_s);
               6'h06: ops_s[0] = enc_r(7'd0, rs_s, rt_s, 3'b101, rd_s);
               6'h07: ops_s[0] = enc_r(F7_ALT, rs_s, rt_s, 3'b101, rd_s);
               6'h08: ops_s[0] = enc_i(12'd0, rs_s, 3'b000, 5'd0, OPC_JALR);
               6'h09: ops_s[0] = enc_i(12'd0, rs_s, 3'b000, rd_s, OPC_JALR);
               6'h0C: ops_s[0] = 32'h0000_0073;
               6'h0D: ops_s[0] = 32'h0010_0073;
               6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
                  if (EN_MULDIV == 1'b0) begin
                     ill_s = 1'b1;
                  end else begin
                     case (funct_s)
                        6'h10: ops_s[0] = enc_i(12'd0, HI_REG, 3'b000, rd_s, OPC_IMM);
                        6'h11: ops_s[0] = enc_i(12'd0, rs_s, 3'b000, HI_REG, OPC_IMM);
                        6'h12: ops_s[0] = enc_i(12'd0, LO_REG, 3'b000, rd_s, OPC_IMM);
                        6'h13: ops_s[0] = enc_i(12'd0, rs_s, 3'b000, LO_REG, OPC_IMM);
                        6'h18: begin
                           n_s      = 3'd2;
                           ops_s[0] = enc_r(F7_MD, rt_s, rs_s, 3'b001, HI_REG);
                           ops_s[1] = enc_r(F7_MD, rt_s, rs_s, 3'b000, LO_REG);
                        end
                        6'h19: begin
                           n_s      = 3'd2;
                           ops_s[0] = enc_r(F7_MD, rt_s, rs_s, 3'b011, HI_REG);
                           ops_s[1] = enc_r(F7_MD, rt_s, rs_s, 3'b000, LO_REG);
                        end
                        6'h1A: begin
                           n_s      = 3'd2;
                           ops_s[0] = enc_r(F7_MD, rt_s, rs_s, 3'b110, HI_REG);
                           ops_s[1] = enc_r(F7_MD, rt_s, rs_s, 3'b100, LO_REG);
                        end
                        6'h1B: begin
                           n_s      = 3'd2;
                           ops_s[0] = enc_r(F7_MD, rt_s, rs_s, 3'b111, HI_REG);
                           ops_s[1] = enc_r(F7_MD, rt_s, rs_s, 3'b101, LO_REG);
                        end
                        default: ill_s = 1'b1;
                     endcase
                  end
               end
               default: ill_s = 1'b1;
            endcase
         end
         6'h02, 6'h03: begin
            if (j_fit_s) begin
               ops_s[0] = enc_j(j_off_s[20:1], (opc_s == 6'h03) ? LINK_REG : 5'd0);
            end else begin
               ill_s = 1'b1;
            end
         end
         6'h04, 6'h05, 6'h06, 6'h07: begin
            if (!br_fit_s) begin
               ill_s = 1'b1;
            end else begin
               case (opc_s)
                  6'h04:   ops_s[0] = enc_b(br_off_s, rt_s, rs_s, 3'b000);
                  6'h05:   ops_s[0] = enc_b(br_off_s, rt_s, rs_s, 3'b001);
                  6'h06:   ops_s[0] = enc_b(br_off_s, rs_s, 5'd0, 3'b101);
                  default: ops_s[0] = enc_b(br_off_s, rs_s, 5'd0, 3'b100);
               endcase
            end
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
            if (imm_fit_s) begin
               ops_s[0] = enc_i(imm_lo_s, rs_s, imm_f3(opc_s), rt_s, OPC_IMM);
            end else begin
               n_s      = 3'd3;
               ops_s[0] = enc_u(imm_hi_s, TMP_REG);
               ops_s[1] = enc_i(imm_lo_s, TMP_REG, 3'b000, TMP_REG, OPC_IMM);
               ops_s[2] = enc_r(7'd0, TMP_REG, rs_s, imm_f3(opc_s), rt_s);
            end
         end
         6'h0F: ops_s[0] = enc_u({imm_s, 4'd0}, rt_s);
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            if (imm_fit_s) begin
               ops_s[0] = enc_i(imm_lo_s, rs_s, ls_f3(opc_s), rt_s, OPC_LOAD);
            end else begin
               n_s      = 3'd3;
               ops_s[0] = enc_u(imm_hi_s, TMP_REG);
               ops_s[1] = enc_r(7'd0, rs_s, TMP_REG, 3'b000, TMP_REG);
               ops_s[2] = enc_i(imm_lo_s, TMP_REG, ls_f3(opc_s), rt_s, OPC_LOAD);
            end
         end
         6'h28, 6'h29, 6'h2B: begin
            if (imm_fit_s) begin
               ops_s[0] = enc_s(imm_lo_s, rt_s, rs_s, ls_f3(opc_s));
            end else begin
               n_s      = 3'd3;
               ops_s[0] = enc_u(imm_hi_s, TMP_REG);
               ops_s[1] = enc_r(7'd0, rs_s, TMP_REG, 3'b000, TMP_REG);
               ops_s[2] = enc_s(imm_lo_s, rt_s, TMP_REG, ls_f3(opc_s));
            end
         end
         default: ill_s = 1'b1;
      endcase
   end

   // Expansion buffer and registered output stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         rem_r       <= 3'd0;
         out_valid   <= 1'b0;
         out_instr   <= 32'd0;
         out_pc      <= 32'd0;
         out_idx     <= 2'd0;
         out_last    <= 1'b0;
         out_illegal <= 1'b0;
         for (int i = 0; i < 4; i++) buf_r[i] <= 32'd0;
      end else if (accept_s) begin
         state_r     <= ST_EMIT;
         rem_r       <= n_s;
         out_valid   <= 1'b1;
         out_instr   <= ops_s[0];
         out_pc      <= in_pc;
         out_idx     <= 2'd0;
         out_last    <= (n_s == 3'd1);
         out_illegal <= ill_s;
         for (int i = 0; i < 4; i++) buf_r[i] <= ops_s[i];
      end else begin
         case (state_r)
            ST_EMIT: begin
               if (xfer_s) begin
                  if (rem_r == 3'd1) begin
                     state_r   <= ST_IDLE;
                     rem_r     <= 3'd0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     rem_r     <= rem_r - 3'd1;
                     out_idx   <= out_idx + 2'd1;
                     out_instr <= buf_r[out_idx + 2'd1];
                     out_last  <= (rem_r == 3'd2);
                  end
               end
            end
            ST_IDLE: state_r <= ST_IDLE;
            default: begin
               state_r   <= ST_IDLE;
               rem_r     <= 3'd0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_to_riscv_seq_translator.sv
// Directed bench for mips_to_riscv_seq_translator: a vector table of hand-encoded
// expansions plus stall, back-to-back and reset-mid-expansion sequences.
module tb_mips_to_riscv_seq_translator;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;
   logic        in_ready, out_valid, out_last, out_illegal;
   logic [31:0] out_instr, out_pc;
   logic [1:0]  out_idx;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      int          n;
      logic [31:0] e [4];
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   mips_to_riscv_seq_translator dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_idx(out_idx), .out_last(out_last), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish (got timeout, required completion)");
      $fatal(1, "bench timeout");
   end

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc, input int n,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic ill);
      vec_t v;
      v.instr = instr; v.pc = pc; v.n = n; v.ill = ill;
      v.e[0] = a; v.e[1] = b; v.e[2] = c; v.e[3] = 32'd0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic chk_op(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input int k, input logic last, input logic ill);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_instr"}, out_instr, instr);
      chk({tag, "_idx"}, {30'd0, out_idx}, k);
      chk({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
      chk({tag, "_pc"}, out_pc, pc);
      chk({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, ill});
   endtask

   // Present one instruction and return at the negedge after it was accepted.
   task automatic send(input logic [31:0] instr, input logic [31:0] pc);
      @(negedge clk);
      in_instr  = instr;
      in_pc     = pc;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         #1;
         if (in_ready) break;
         @(negedge clk);
      end
      chk("send_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      send(v.instr, v.pc);
      for (int k = 0; k < v.n; k++) begin
         chk_op($sformatf("v%0d_op%0d", id, k), v.e[k], v.pc, k, (k == v.n - 1), v.ill);
         @(negedge clk);
      end
      chk($sformatf("v%0d_drained", id), {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'd0; in_pc = 32'd0;

      vecs.push_back(mk(32'h0022_1820, 32'h0040_0000, 1, 32'h0020_81B3, 0, 0, 1'b0)); // ADD
      vecs.push_back(mk(32'h8C82_07FF, 32'h0040_0004, 1, 32'h7FF2_2103, 0, 0, 1'b0)); // LW 0x7FF
      vecs.push_back(mk(32'h8C82_0800, 32'h0040_0008, 3, 32'h0000_10B7, 32'h0040_80B3,
                        32'h8000_A103, 1'b0));                                         // LW 0x800
      vecs.push_back(mk(32'h2485_FFFF, 32'h0040_000C, 1, 32'hFFF2_0293, 0, 0, 1'b0)); // ADDIU -1
      vecs.push_back(mk(32'h3485_FFFF, 32'h0040_0010, 3, 32'h0001_00B7, 32'hFFF0_8093,
                        32'h0012_62B3, 1'b0));                                         // ORI 0xFFFF
      vecs.push_back(mk(32'h0002_1900, 32'h0040_0014, 1, 32'h0041_1193, 0, 0, 1'b0)); // SLL
      vecs.push_back(mk(32'h0002_1903, 32'h0040_0018, 1, 32'h4041_5193, 0, 0, 1'b0)); // SRA
      vecs.push_back(mk(32'h0022_0018, 32'h0040_001C, 2, 32'h0220_9D33, 32'h0220_8DB3,
                        0, 1'b0));                                                     // MULT
      vecs.push_back(mk(32'h0022_001B, 32'h0040_0020, 2, 32'h0220_FD33, 32'h0220_DDB3,
                        0, 1'b0));                                                     // DIVU
      vecs.push_back(mk(32'h0000_1810, 32'h0040_0024, 1, 32'h000D_0193, 0, 0, 1'b0)); // MFHI
      vecs.push_back(mk(32'h1022_0003, 32'h0040_0028, 1, 32'h0020_8863, 0, 0, 1'b0)); // BEQ +16
      vecs.push_back(mk(32'h1422_FFFF, 32'h0040_002C, 1, 32'h0020_9063, 0, 0, 1'b0)); // BNE 0
      vecs.push_back(mk(32'h1022_03FE, 32'h0040_0030, 1, 32'h7E20_8EE3, 0, 0, 1'b0)); // BEQ 4092
      vecs.push_back(mk(32'h1022_03FF, 32'h0040_0034, 1, 32'h0000_0000, 0, 0, 1'b1)); // BEQ 4096
      vecs.push_back(mk(32'h1880_0001, 32'h0040_0038, 1, 32'h0040_5463, 0, 0, 1'b0)); // BLEZ
      vecs.push_back(mk(32'h0820_0000, 32'h0000_0000, 1, 32'h0000_0000, 0, 0, 1'b1)); // J 8MiB
      vecs.push_back(mk(32'h0800_0500, 32'h0000_1000, 1, 32'h4000_006F, 0, 0, 1'b0)); // J +0x400
      vecs.push_back(mk(32'h0C00_0500, 32'h0000_1000, 1, 32'h4000_0FEF, 0, 0, 1'b0)); // JAL
      vecs.push_back(mk(32'h0C00_0400, 32'h0000_2000, 1, 32'h800F_FFEF, 0, 0, 1'b0)); // JAL back
      vecs.push_back(mk(32'h03E0_0008, 32'h0040_003C, 1, 32'h000F_8067, 0, 0, 1'b0)); // JR
      vecs.push_back(mk(32'h0000_000C, 32'h0040_0040, 1, 32'h0000_0073, 0, 0, 1'b0)); // SYSCALL
      vecs.push_back(mk(32'h0000_000D, 32'h0040_0044, 1, 32'h0010_0073, 0, 0, 1'b0)); // BREAK
      vecs.push_back(mk(32'hFC00_0000, 32'h0040_0048, 1, 32'h0000_0000, 0, 0, 1'b1)); // op 0x3F
      vecs.push_back(mk(32'hAC82_FFFC, 32'h0040_004C, 1, 32'hFE22_2E23, 0, 0, 1'b0)); // SW -4
      vecs.push_back(mk(32'h3C05_1234, 32'h0040_0050, 1, 32'h1234_02B7, 0, 0, 1'b0)); // LUI

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_idx", {30'd0, out_idx}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_out_ill", {31'd0, out_illegal}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // NOR with the downstream stalled
      send(32'h0022_1827, 32'h0040_1000);
      out_ready = 1'b0;
      #1;
      chk_op("nor_op0", 32'h0020_E1B3, 32'h0040_1000, 0, 1'b0, 1'b0);
      chk("nor_in_ready0", {31'd0, in_ready}, 32'd0);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk_op($sformatf("nor_stall%0d", s), 32'h0020_E1B3, 32'h0040_1000, 0, 1'b0, 1'b0);
         chk($sformatf("nor_stall%0d_in_ready", s), {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("nor_in_ready_rem2", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk_op("nor_op1", 32'hFFF1_C193, 32'h0040_1000, 1, 1'b1, 1'b0);
      chk("nor_in_ready_last", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("nor_drained", {31'd0, out_valid}, 32'd0);

      // ADDI wide immediate, next instruction accepted as op 2 is taken
      send(32'h2085_1234, 32'h0040_2000);
      chk_op("addi_op0", 32'h0000_10B7, 32'h0040_2000, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk_op("addi_op1", 32'h2340_8093, 32'h0040_2000, 1, 1'b0, 1'b0);
      @(negedge clk);
      chk_op("addi_op2", 32'h0012_02B3, 32'h0040_2000, 2, 1'b1, 1'b0);
      in_instr = 32'h0022_1820;
      in_pc    = 32'h0040_2004;
      in_valid = 1'b1;
      #1;
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk_op("b2b_add", 32'h0020_81B3, 32'h0040_2004, 0, 1'b1, 1'b0);
      @(negedge clk);
      chk("b2b_drained", {31'd0, out_valid}, 32'd0);

      // reset in the middle of a MULT expansion
      send(32'h0022_0018, 32'h0040_3000);
      chk_op("mrst_op0", 32'h0220_9D33, 32'h0040_3000, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk_op("mrst_op1", 32'h0220_8DB3, 32'h0040_3000, 1, 1'b1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mrst_out_instr", out_instr, 32'd0);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk($sformatf("mrst_quiet%0d", s), {31'd0, out_valid}, 32'd0);
      end
      run_vec(mk(32'h0022_1820, 32'h0040_3004, 1, 32'h0020_81B3, 0, 0, 1'b0), 99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
